// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 size/sign codes, FSM states and
// the request legality check used on accept.
package load_store_unit_pkg;

  localparam logic [2:0] Lb  = 3'b000;
  localparam logic [2:0] Lh  = 3'b001;
  localparam logic [2:0] Lw  = 3'b010;
  localparam logic [2:0] Lbu = 3'b100;
  localparam logic [2:0] Lhu = 3'b101;
  localparam logic [2:0] Sb  = 3'b000;
  localparam logic [2:0] Sh  = 3'b001;
  localparam logic [2:0] Sw  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWrite,
    StResp
  } lsu_state_e;

  // Misaligned access or funct3 outside the legal set for the direction.
  function automatic logic req_is_bad(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    if (we) begin
      case (funct3)
        Sb:      bad = 1'b0;
        Sh:      bad = addr_lo[0];
        Sw:      bad = (addr_lo != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        Lb, Lbu: bad = 1'b0;
        Lh, Lhu: bad = addr_lo[0];
        Lw:      bad = (addr_lo != 2'b00);
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane extraction with sign/zero extension for loads and lane merge for sub-word stores.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rword_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_lane = rword_i[7:0];
      2'd1:    byte_lane = rword_i[15:8];
      2'd2:    byte_lane = rword_i[23:16];
      default: byte_lane = rword_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    case (funct3_i)
      Lb:      load_data_o = {{24{byte_lane[7]}}, byte_lane};
      Lh:      load_data_o = {{16{half_lane[15]}}, half_lane};
      Lbu:     load_data_o = {24'b0, byte_lane};
      Lhu:     load_data_o = {16'b0, half_lane};
      default: load_data_o = rword_i;
    endcase

    store_word_o = rword_i;
    if (funct3_i == Sb) begin
      store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
    end else if (funct3_i == Sh) begin
      if (addr_lo_i[1]) store_word_o[31:16] = wdata_i;
      else              store_word_o[15:0]  = wdata_i;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit: latches a CPU request, performs a word read,
// read-modify-write or word write on data memory, and returns a held response.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [15:0] wdata_q;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_ready = (state_q == StIdle);

  lsu_align u_align (
    .funct3_i     (funct3_q),
    .addr_lo_i    (addr_lo_q),
    .rword_i      (mem_RD),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      wdata_q    <= 16'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_A      <= 32'h0;
      mem_WD     <= 32'h0;
      mem_WE     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            if (req_is_bad(req_we, req_funct3, req_addr[1:0])) begin
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
              resp_valid <= 1'b1;
              state_q    <= StResp;
            end else begin
              mem_A <= {req_addr[31:2], 2'b00};
              // Full-word stores need no read, so they skip straight to the write.
              if (req_we && (req_funct3 == Sw)) begin
                mem_WD  <= req_wdata;
                mem_WE  <= 1'b1;
                state_q <= StWrite;
              end else begin
                state_q <= StAccess;
              end
            end
          end
        end
        StAccess: begin
          if (we_q) begin
            mem_WD  <= store_word;
            mem_WE  <= 1'b1;
            state_q <= StWrite;
          end else begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state_q    <= StResp;
          end
        end
        StWrite: begin
          mem_WE     <= 1'b0;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; all datapaths are fixed 32-bit, byte-addressed, little-endian.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  CPU request present.
REQ-005 req_ready  out  1  block can accept a request; high only in IDLE.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 only (stores).
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data; B/H use the low 8/16 bits.
REQ-010 resp_valid  out  1  response present; held until accepted.
REQ-011 resp_ready  in  1  CPU accepts response.
REQ-012 resp_rdata  out  32  load result, sign/zero-extended; 0 for stores and errors.
REQ-013 resp_err  out  1  misaligned or illegal request; no memory write issued.
REQ-014 mem_A  out  32  word address to data memory, always {addr[31:2],2'b00}.
REQ-015 mem_WD  out  32  write word to data memory.
REQ-016 mem_WE  out  1  write enable; memory writes on rising clk edge.
REQ-017 mem_RD  in  32  combinational read word from mem_A.

Function
REQ-018 Handshake: request accepted on the rising edge where req_valid and req_ready are both 1; inputs are latched then and ignored afterwards.
REQ-019 FSM states: IDLE, ACCESS, WRITE, RESP.
REQ-020 IDLE -> RESP on accept with resp_err=1 if: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0; funct3 outside REQ-007's legal set (loads: 011/110/111; stores: any except 000/001/010).
REQ-021 IDLE -> WRITE for a legal SW; IDLE -> ACCESS for a legal load, SB or SH.
REQ-022 ACCESS: mem_WE=0; mem_RD is sampled at the end of the cycle; a load goes to RESP and a sub-word store goes to WRITE.
REQ-023 WRITE: mem_WE=1 for exactly one cycle. mem_WD is req_wdata for SW. For SB/SH, mem_WD is the sampled word with only the addressed byte/halfword lane replaced. Then -> RESP.
REQ-024 Load extraction lane = addr[1:0] (byte) or addr[1] (half); B/H sign-extend bit 7/15; BU/HU zero-extend.
REQ-025 RESP: resp_valid=1 with stable rdata/err; -> IDLE on the edge where resp_ready=1. A new request can be accepted no earlier than the following cycle.
REQ-026 Latency from accept edge to resp_valid: error 1 cycle; load 2; SW 2; SB/SH 3.
REQ-027 mem_WE=0 in every state except WRITE. mem_A holds its last value outside ACCESS/WRITE.
REQ-028 Address wrap: no boundary check; 0xFFFFFFFC is a legal word address.

Reset
REQ-029 While rst_n=0: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_A=0, mem_WD=0, mem_WE=0, all latches 0.
REQ-030 Reset asserted in any state aborts the operation immediately; mem_WE drops asynchronously and no response is produced.

Structure
REQ-031 A shared package holds the funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enumeration.
REQ-032 One combinational sub-module, lsu_align, does lane extraction/extension and store merge; the FSM and registers stay in load_store_unit.

Verification
REQ-033 Memory word 0x100 = 0x8077F0AA; LB addr 0x101 -> resp_rdata=0xFFFFFFF0, resp_valid 2 cycles after accept; LBU 0x103 -> 0x00000080.
REQ-034 Same word; SH addr 0x102, wdata 0x1234 -> exactly one mem_WE pulse with mem_WD=0x1234F0AA; memory word reads back 0x1234F0AA.
REQ-035 SW addr 0x200, wdata 0xDEADBEEF -> mem_WE at cycle 1 with mem_A=0x200; resp at cycle 2, rdata=0, err=0.
REQ-036 LW addr 0x102 and SH addr 0x003 -> resp_err=1 after 1 cycle; mem_WE never asserted.
REQ-037 resp_ready held 0 for 5 cycles -> resp_valid/rdata stable and req_ready=0 throughout; req_valid ignored.
REQ-038 rst_n pulled low during the ACCESS state of an SB -> mem_WE stays 0, memory unchanged, outputs at reset values, req_ready=1 after release.
